alarm_sequencer: RTL and testbench
==================================

Name: alarm_sequencer

Overview:
Alarm-state controller that decides when the alarm light and alarm music run. It compares the running time-of-day against the programmed alarm time and sequences IDLE/ARMED/RINGING/SNOOZE. It drives the turned_on input of the alarm light and music blocks, and it owns the snooze and auto-timeout timing. It sits between the timekeeping counters, the user buttons and the alarm output blocks.

Parameters:
SNOOZE_S, 300, seconds spent in SNOOZE before re-ringing (1..4095)
RING_TIMEOUT_S, 600, seconds of continuous RINGING before auto-stop (1..4095)
MAX_SNOOZE, 3, snoozes allowed per alarm event (0..7)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset (0 = reset)
tick_1hz  in  1  one-clk-wide pulse, once per second
cur_hour  in  5  current hour, 0..23
cur_min  in  6  current minute, 0..59
cur_sec  in  6  current second, 0..59
alarm_hour  in  5  programmed alarm hour
alarm_min  in  6  programmed alarm minute
arm  in  1  level: alarm enabled switch
snooze_btn  in  1  one-clk pulse, debounced externally
stop_btn  in  1  one-clk pulse, debounced externally
turned_on  out  1  high while RINGING; drives alarm light/music
snoozing  out  1  high while in SNOOZE
missed  out  1  sticky; set on timeout, cleared by stop_btn or arm falling
snooze_left  out  3  remaining snoozes for the current event
state  out  2  IDLE=0, ARMED=1, RINGING=2, SNOOZE=3

Behaviour:
- Reset (reset==0, async): state=IDLE, turned_on=0, snoozing=0, missed=0, snooze_left=MAX_SNOOZE, second counter=0. All outputs are registered.
- match = tick_1hz & (cur_hour==alarm_hour) & (cur_min==alarm_min) & (cur_sec==0). Values are sampled in the tick cycle. Firing only on second 0 prevents a re-trigger after stop within the same minute.
- IDLE: arm=1 -> ARMED next clk.
- ARMED: arm=0 -> IDLE. match -> RINGING, clear sec counter, snooze_left=MAX_SNOOZE.
- RINGING: turned_on=1 from the cycle after the transition (1-clk latency). Priority, highest first:
  - arm=0 -> IDLE
  - stop_btn -> ARMED
  - snooze_btn with snooze_left>0 -> SNOOZE, snooze_left-1, clear counter
  - counter reaches RING_TIMEOUT_S-1 on a tick -> ARMED, missed=1
  - snooze_btn with snooze_left==0 is ignored.
- SNOOZE: turned_on=0, snoozing=1. Priority: arm=0 -> IDLE; stop_btn -> ARMED. When the counter reaches SNOOZE_S-1 on a tick -> RINGING, counter cleared. The RING_TIMEOUT_S window restarts on each re-ring. snooze_btn is ignored.
- Sec counter: 12 bits; increments on tick_1hz only in RINGING/SNOOZE, cleared on every state change. No wrap: the state transition occurs first.
- Simultaneous events: stop beats snooze beats timeout; arm=0 beats all. match arriving in RINGING/SNOOZE is ignored.
- missed: set on timeout, cleared by stop_btn in any state or by arm going 0. A set and a clear in the same cycle: set wins.
- Time inputs out of range (e.g. hour 25) never match and need no further handling.

Optional Feature:
Macro ALARM_SNOOZE_EN.
- Defined: snooze behaviour exactly as above.
- Undefined: the SNOOZE state is unreachable and snooze_btn is ignored. snoozing is tied 0 and snooze_left is tied 0. RINGING exits only via stop, arm=0 or timeout. The MAX_SNOOZE and SNOOZE_S parameters remain declared but unused.

Decomposition:
- Package alarm_pkg: state encoding constants (ST_IDLE, ST_ARMED, ST_RINGING, ST_SNOOZE), hour/min/sec width constants, counter width 12.
- One sub-module, alarm_sec_timer: a tick-driven 12-bit counter with clear, compare value input and done output. It is instantiated once and its compare is muxed between SNOOZE_S and RING_TIMEOUT_S by state.
- The FSM and output registers stay in alarm_sequencer.

Test Plan:
- Reset checks:
  - reset=0 mid-RINGING -> turned_on=0 and state=0 immediately (async); after release, arm=1 -> state=1 after 1 clk.
- Basic alarm flow:
  - Alarm 07:30, arm=1, tick with cur=07:30:00 -> state=2 and turned_on=1 one clk later.
  - stop_btn -> state=1 and turned_on=0.
  - A tick at 07:30:05 does not re-trigger.
- Snooze (ALARM_SNOOZE_EN, SNOOZE_S=5, MAX_SNOOZE=2):
  - snooze_btn while ringing -> state=3, snooze_left=1; after 5 ticks -> state=2.
  - Second snooze -> snooze_left=0.
  - Third snooze_btn is ignored; state stays 2.
- Timeout (RING_TIMEOUT_S=10):
  - No buttons for 10 ticks -> state=1, missed=1.
  - stop_btn -> missed=0.
- Simultaneous button events:
  - stop_btn and snooze_btn in the same clk while ringing -> state=1, snooze_left unchanged.
  - arm=0 together with stop_btn -> state=0.
- Snooze compiled out (ALARM_SNOOZE_EN undefined):
  - snooze_btn while ringing -> state stays 2, snoozing=0, snooze_left=0.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared widths and state encoding for the alarm sequencer slice.
package alarm_pkg;
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int CNT_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_t;
endpackage

// File: rtl/alarm_sec_timer.sv
// Tick-driven seconds counter; done is combinational on the tick that completes `limit` seconds.
// Clear wins over counting; no backpressure, counter never wraps in use.
module alarm_sec_timer
    import alarm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             en,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);
    logic [CNT_W-1:0] count;

    assign done = en & tick & (count == limit - CNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && tick) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/alarm_sequencer.sv
// Alarm FSM (IDLE/ARMED/RINGING/SNOOZE) driving the light/music enable; outputs registered, 1-clk latency.
// ALARM_SNOOZE_EN enables the snooze path; without it SNOOZE is unreachable and snooze outputs tie low.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int SNOOZE_S       = 300,
    parameter int RING_TIMEOUT_S = 600,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MIN_W-1:0]  alarm_min,
    input  logic              arm,
    input  logic              snooze_btn,
    input  logic              stop_btn,
    output logic              turned_on,
    output logic              snoozing,
    output logic              missed,
    output logic [2:0]        snooze_left,
    output logic [1:0]        state
);
    if (SNOOZE_S < 1 || SNOOZE_S > 4095 || RING_TIMEOUT_S < 1 || RING_TIMEOUT_S > 4095 ||
        MAX_SNOOZE < 0 || MAX_SNOOZE > 7) begin : g_param_chk
        $error("alarm_sequencer: parameter out of range");
    end

    state_t           st_q, st_d;
    logic             arm_q;
    logic             match;
    logic             timeout;
    logic             snooze_take;
    logic             event_start;
    logic             tmr_done;
    logic             tmr_en;
    logic             tmr_clr;
    logic [CNT_W-1:0] tmr_limit;

    // Firing only on second 0 keeps a stopped alarm from re-triggering within the minute.
    assign match = tick_1hz & (cur_hour == alarm_hour) & (cur_min == alarm_min) & (cur_sec == '0);

    assign tmr_en    = (st_q == ST_RINGING) | (st_q == ST_SNOOZE);
    assign tmr_clr   = (st_d != st_q);
    assign tmr_limit = (st_q == ST_SNOOZE) ? CNT_W'(SNOOZE_S) : CNT_W'(RING_TIMEOUT_S);

    alarm_sec_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_1hz),
        .en    (tmr_en),
        .clear (tmr_clr),
        .limit (tmr_limit),
        .done  (tmr_done)
    );

    always_comb begin
        st_d        = st_q;
        timeout     = 1'b0;
        snooze_take = 1'b0;
        event_start = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (arm) st_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!arm) begin
                    st_d = ST_IDLE;
                end else if (match) begin
                    st_d        = ST_RINGING;
                    event_start = 1'b1;
                end
            end
            ST_RINGING: begin
                if (!arm) begin
                    st_d = ST_IDLE;
                end else if (stop_btn) begin
                    st_d = ST_ARMED;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze_btn && (snooze_left != 3'd0)) begin
                    st_d        = ST_SNOOZE;
                    snooze_take = 1'b1;
`endif
                end else if (tmr_done) begin
                    st_d    = ST_ARMED;
                    timeout = 1'b1;
                end
            end
            ST_SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
                if (!arm) begin
                    st_d = ST_IDLE;
                end else if (stop_btn) begin
                    st_d = ST_ARMED;
                end else if (tmr_done) begin
                    st_d = ST_RINGING;
                end
`else
                st_d = ST_IDLE;
`endif
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q      <= ST_IDLE;
            turned_on <= 1'b0;
            snoozing  <= 1'b0;
            missed    <= 1'b0;
            arm_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            turned_on <= (st_d == ST_RINGING);
            snoozing  <= (st_d == ST_SNOOZE);
            arm_q     <= arm;
            // A timeout in the same cycle as a clear leaves missed set.
            if (timeout) begin
                missed <= 1'b1;
            end else if (stop_btn || (arm_q && !arm)) begin
                missed <= 1'b0;
            end
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snooze_left <= 3'(MAX_SNOOZE);
        end else if (event_start) begin
            snooze_left <= 3'(MAX_SNOOZE);
        end else if (snooze_take) begin
            snooze_left <= snooze_left - 3'd1;
        end
    end
`else
    logic snooze_unused;
    assign snooze_unused = ^{snooze_btn, event_start, snooze_take};
    assign snooze_left   = 3'd0;
`endif

    assign state = st_q;
endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer (SNOOZE_S=5, RING_TIMEOUT_S=10, MAX_SNOOZE=2), both ALARM_SNOOZE_EN builds.
module tb_alarm_sequencer;
    logic       clk = 1'b0;
    logic       reset, tick_1hz, arm, snooze_btn, stop_btn;
    logic [4:0] cur_hour, alarm_hour;
    logic [5:0] cur_min, cur_sec, alarm_min;
    logic       turned_on, snoozing, missed;
    logic [2:0] snooze_left;
    logic [1:0] state;

    int pass_cnt = 0;
    int total    = 0;

`ifdef ALARM_SNOOZE_EN
    localparam logic [2:0] EXP_MAX = 3'd2;
`else
    localparam logic [2:0] EXP_MAX = 3'd0;
`endif

    always #5 clk = ~clk;

    alarm_sequencer #(.SNOOZE_S(5), .RING_TIMEOUT_S(10), .MAX_SNOOZE(2)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .arm(arm), .snooze_btn(snooze_btn), .stop_btn(stop_btn),
        .turned_on(turned_on), .snoozing(snoozing), .missed(missed),
        .snooze_left(snooze_left), .state(state)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_at(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_hour = h; cur_min = m; cur_sec = s;
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic press_stop;
        stop_btn = 1'b1;
        step();
        stop_btn = 1'b0;
    endtask

    task automatic press_snooze;
        snooze_btn = 1'b1;
        step();
        snooze_btn = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; tick_1hz = 1'b0; arm = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
        cur_hour = 5'd0; cur_min = 6'd0; cur_sec = 6'd0;
        alarm_hour = 5'd7; alarm_min = 6'd30;
        #12;
        total++; if (state !== 2'd0) $display("FAIL reset_state got=%0d want=0", state); else pass_cnt++;
        total++; if (turned_on !== 1'b0) $display("FAIL reset_turned_on got=%0b want=0", turned_on); else pass_cnt++;
        total++; if (snoozing !== 1'b0) $display("FAIL reset_snoozing got=%0b want=0", snoozing); else pass_cnt++;
        total++; if (missed !== 1'b0) $display("FAIL reset_missed got=%0b want=0", missed); else pass_cnt++;
        total++; if (snooze_left !== EXP_MAX) $display("FAIL reset_snooze_left got=%0d want=%0d", snooze_left, EXP_MAX); else pass_cnt++;
        step();
        reset = 1'b1;
        arm   = 1'b1;
        step();
        total++; if (state !== 2'd1) $display("FAIL arm_to_armed got=%0d want=1", state); else pass_cnt++;
    endtask

    task automatic test_basic;
        tick_at(5'd7, 6'd29, 6'd0);
        total++; if (state !== 2'd1) $display("FAIL wrong_minute_no_ring got=%0d want=1", state); else pass_cnt++;
        tick_at(5'd7, 6'd30, 6'd0);
        total++; if (state !== 2'd2) $display("FAIL match_ring_state got=%0d want=2", state); else pass_cnt++;
        total++; if (turned_on !== 1'b1) $display("FAIL match_turned_on got=%0b want=1", turned_on); else pass_cnt++;
        total++; if (snooze_left !== EXP_MAX) $display("FAIL match_snooze_left got=%0d want=%0d", snooze_left, EXP_MAX); else pass_cnt++;
        press_stop();
        total++; if (state !== 2'd1) $display("FAIL stop_state got=%0d want=1", state); else pass_cnt++;
        total++; if (turned_on !== 1'b0) $display("FAIL stop_turned_on got=%0b want=0", turned_on); else pass_cnt++;
        tick_at(5'd7, 6'd30, 6'd5);
        total++; if (state !== 2'd1) $display("FAIL no_retrigger got=%0d want=1", state); else pass_cnt++;
        tick_at(5'd25, 6'd30, 6'd0);
        total++; if (state !== 2'd1) $display("FAIL bad_hour_no_ring got=%0d want=1", state); else pass_cnt++;
    endtask

`ifdef ALARM_SNOOZE_EN
    task automatic test_snooze;
        tick_at(5'd7, 6'd30, 6'd0);
        press_snooze();
        total++; if (state !== 2'd3) $display("FAIL snooze1_state got=%0d want=3", state); else pass_cnt++;
        total++; if (snooze_left !== 3'd1) $display("FAIL snooze1_left got=%0d want=1", snooze_left); else pass_cnt++;
        total++; if (snoozing !== 1'b1 || turned_on !== 1'b0) $display("FAIL snooze1_outs got=%0b%0b want=10", snoozing, turned_on); else pass_cnt++;
        for (int i = 0; i < 4; i++) tick_at(5'd7, 6'd30, 6'd10);
        total++; if (state !== 2'd3) $display("FAIL snooze_4ticks got=%0d want=3", state); else pass_cnt++;
        tick_at(5'd7, 6'd30, 6'd10);
        total++; if (state !== 2'd2) $display("FAIL rering_state got=%0d want=2", state); else pass_cnt++;
        total++; if (turned_on !== 1'b1 || snoozing !== 1'b0) $display("FAIL rering_outs got=%0b%0b want=10", turned_on, snoozing); else pass_cnt++;
        press_snooze();
        total++; if (snooze_left !== 3'd0 || state !== 2'd3) $display("FAIL snooze2 got=left%0d/st%0d want=left0/st3", snooze_left, state); else pass_cnt++;
        for (int i = 0; i < 5; i++) tick_at(5'd7, 6'd30, 6'd20);
        total++; if (state !== 2'd2) $display("FAIL rering2_state got=%0d want=2", state); else pass_cnt++;
        press_snooze();
        total++; if (state !== 2'd2) $display("FAIL snooze3_ignored got=%0d want=2", state); else pass_cnt++;
        press_stop();
        total++; if (state !== 2'd1) $display("FAIL snooze_stop got=%0d want=1", state); else pass_cnt++;
    endtask
`else
    task automatic test_snooze;
        tick_at(5'd7, 6'd30, 6'd0);
        press_snooze();
        total++; if (state !== 2'd2) $display("FAIL nosnooze_state got=%0d want=2", state); else pass_cnt++;
        total++; if (snoozing !== 1'b0) $display("FAIL nosnooze_snoozing got=%0b want=0", snoozing); else pass_cnt++;
        total++; if (snooze_left !== 3'd0) $display("FAIL nosnooze_left got=%0d want=0", snooze_left); else pass_cnt++;
        press_stop();
        total++; if (state !== 2'd1) $display("FAIL nosnooze_stop got=%0d want=1", state); else pass_cnt++;
    endtask
`endif

    task automatic test_timeout;
        tick_at(5'd7, 6'd30, 6'd0);
        for (int i = 0; i < 9; i++) tick_at(5'd7, 6'd30, 6'd30);
        total++; if (state !== 2'd2) $display("FAIL timeout_9ticks got=%0d want=2", state); else pass_cnt++;
        tick_at(5'd7, 6'd30, 6'd30);
        total++; if (state !== 2'd1) $display("FAIL timeout_state got=%0d want=1", state); else pass_cnt++;
        total++; if (missed !== 1'b1) $display("FAIL timeout_missed got=%0b want=1", missed); else pass_cnt++;
        total++; if (turned_on !== 1'b0) $display("FAIL timeout_turned_on got=%0b want=0", turned_on); else pass_cnt++;
        press_stop();
        total++; if (missed !== 1'b0) $display("FAIL stop_clears_missed got=%0b want=1'b0", missed); else pass_cnt++;
        tick_at(5'd7, 6'd30, 6'd0);
        for (int i = 0; i < 10; i++) tick_at(5'd7, 6'd30, 6'd30);
        total++; if (missed !== 1'b1) $display("FAIL timeout2_missed got=%0b want=1", missed); else pass_cnt++;
        arm = 1'b0;
        step();
        total++; if (missed !== 1'b0 || state !== 2'd0) $display("FAIL disarm_clear got=m%0b/st%0d want=m0/st0", missed, state); else pass_cnt++;
        arm = 1'b1;
        step();
    endtask

    task automatic test_simultaneous;
        tick_at(5'd7, 6'd30, 6'd0);
        stop_btn = 1'b1; snooze_btn = 1'b1;
        step();
        stop_btn = 1'b0; snooze_btn = 1'b0;
        total++; if (state !== 2'd1) $display("FAIL stop_beats_snooze got=%0d want=1", state); else pass_cnt++;
        total++; if (snooze_left !== EXP_MAX) $display("FAIL stop_snooze_left got=%0d want=%0d", snooze_left, EXP_MAX); else pass_cnt++;
        tick_at(5'd7, 6'd30, 6'd0);
        arm = 1'b0; stop_btn = 1'b1;
        step();
        stop_btn = 1'b0;
        total++; if (state !== 2'd0) $display("FAIL disarm_beats_stop got=%0d want=0", state); else pass_cnt++;
        arm = 1'b1;
        step();
        total++; if (state !== 2'd1) $display("FAIL rearm got=%0d want=1", state); else pass_cnt++;
    endtask

    task automatic test_async_reset;
        tick_at(5'd7, 6'd30, 6'd0);
        total++; if (turned_on !== 1'b1) $display("FAIL pre_reset_ringing got=%0b want=1", turned_on); else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        total++; if (state !== 2'd0 || turned_on !== 1'b0) $display("FAIL async_reset got=st%0d/on%0b want=st0/on0", state, turned_on); else pass_cnt++;
        step();
        reset = 1'b1;
        step();
        total++; if (state !== 2'd1) $display("FAIL post_reset_arm got=%0d want=1", state); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_snooze();
        test_timeout();
        test_simultaneous();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
